pc_redirect_ctrl: RTL and testbench
===================================

# pc_redirect_ctrl

Fetch-side consumer of the branch outcome: holds the 19-bit fetch PC, applies taken-branch, call and return redirects from execute, keeps a return-address stack (RAS) for call/ret, and squashes wrong-path instructions with a timed flush. Sits between `branch_control` in execute and the instruction-fetch stage of the 19-bit CPU.

## Interface
- `RESET_PC`, 19'h0: fetch PC loaded on reset.
- `RAS_DEPTH`, 8: return-address stack entries, power of two, 2..16.
- `FLUSH_CYCLES`, 2: cycles `flush_o` stays high per redirect, 1..7.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `valid_i` in 1: execute-stage instruction is valid.
- `stall_i` in 1: pipeline stall; freezes all state.
- `is_b_type_ctl_i` in 1: execute instruction is branch/call/ret.
- `instr_func3_ctl_i` in 3: 0–5 conditional branches, 6 call, 7 ret.
- `branch_taken_i` in 1: outcome from `branch_control`.
- `pc_i` in 19: PC of the execute instruction.
- `imm_i` in 19: signed branch/call offset in words.
- `pc_o` out 19: fetch PC, registered.
- `flush_o` out 1: squash younger instructions, registered.
- `ras_count_o` out `$clog2(RAS_DEPTH)+1`: valid RAS entries.
- `ras_ovf_o` out 1: sticky, a push dropped the oldest entry.
- `ras_unf_o` out 1: sticky, a ret hit an empty RAS.

## Operation
- Reset state: `pc_o`=`RESET_PC`, `flush_o`=0, `ras_count_o`=0, `ras_ovf_o`=0, `ras_unf_o`=0, FSM=RUN, RAS contents don't-care.
- Accept condition: `valid_i` & `is_b_type_ctl_i` & !`stall_i` & FSM=RUN. While FSM=FLUSH, `valid_i` is ignored because those are wrong-path instructions.
- Conditional branches (func3 0–5):
  - `branch_taken_i`=1: redirect to `pc_i`+`imm_i`.
  - `branch_taken_i`=0: no redirect.
- Call (func3 6), unconditional (`branch_taken_i` ignored):
  - Push `pc_i`+1 onto the RAS.
  - Redirect to `pc_i`+`imm_i`.
- Ret (func3 7), unconditional:
  - RAS non-empty: pop and redirect to the popped value.
  - RAS empty: no redirect, no flush, set `ras_unf_o`, count stays 0.
- Arithmetic: all address sums are modulo 2^19. `imm_i` is two's complement, so wrap-around at 19'h7FFFF→0 and 0→19'h7FFFF is legal.
- RAS is a circular buffer with top pointer and count:
  - Push when count=`RAS_DEPTH` overwrites the oldest entry, keeps count at `RAS_DEPTH`, and sets `ras_ovf_o`.
  - Only one push or pop per cycle; call and ret are mutually exclusive by encoding.
- FSM has two states:
  - RUN → FLUSH on a redirect. The flush counter loads `FLUSH_CYCLES`-1.
  - FLUSH: `flush_o`=1. Counter decrements each unstalled cycle. FLUSH → RUN when counter=0.
- No redirect and no stall: `pc_o` ← `pc_o`+1, including during FLUSH, since fetch continues from the new target.
- `stall_i`=1 holds `pc_o`, the RAS, the FSM, the counter and `flush_o`.
- Sticky flags clear only on reset.
- Reset mid-flush or mid-push returns everything to the reset state immediately (asynchronous).

## Timing
- Redirect latency is 1 cycle. For an instruction accepted at edge N:
  - `pc_o`=target after edge N.
  - `flush_o`=1 for exactly `FLUSH_CYCLES` unstalled cycles starting after edge N.
- `ras_count_o` and the flags update at the same edge as the push or pop.
- A stall cycle inside FLUSH extends `flush_o` by one cycle.
- Back-to-back redirects are impossible: the second instruction arrives during FLUSH and is ignored.
- No combinational path from any input to any output.

## Test plan
- Reset, then 3 unstalled cycles → `pc_o` = 0,1,2,3; `flush_o`=0 throughout.
- BEQ (func3 0) at `pc_i`=0x00010, `imm_i`=0x00008, taken=1 → `pc_o`=0x00018 next cycle; `flush_o`=1 for 2 cycles; a `valid_i` branch during the flush is ignored. Same with taken=0 → no redirect.
- Call at `pc_i`=0x00100, `imm_i`=0x7FF00 (−256) → `pc_o`=0x00000, `ras_count_o`=1. A later ret → `pc_o`=0x00101, `ras_count_o`=0.
- 9 calls with `pc_i`=1..9 (after each flush drains) → `ras_ovf_o`=1, count=8. Then 8 rets → targets 10,9,…,3. A ninth ret → `ras_unf_o`=1, no flush, `pc_o` increments.
- Wrap: `pc_i`=0x7FFFE, `imm_i`=3, taken BNE → `pc_o`=0x00001.
- `stall_i`=1 for 3 cycles in FLUSH → `pc_o` held, `flush_o` stays high 5 cycles total. Assert `reset_n`=0 mid-flush → `flush_o`=0 and `pc_o`=`RESET_PC` immediately, before the next edge.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC register applying branch/call/ret redirects from execute,
// with a circular return-address stack and a timed wrong-path flush.
module pc_redirect_ctrl #(
  parameter logic [18:0] RESET_PC     = 19'h0,
  parameter int          RAS_DEPTH    = 8,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         valid_i,
  input  logic                         stall_i,
  input  logic                         is_b_type_ctl_i,
  input  logic [2:0]                   instr_func3_ctl_i,
  input  logic                         branch_taken_i,
  input  logic [18:0]                  pc_i,
  input  logic [18:0]                  imm_i,
  output logic [18:0]                  pc_o,
  output logic                         flush_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
  output logic                         ras_ovf_o,
  output logic                         ras_unf_o
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t        state;
  logic [2:0]    cnt;
  logic [AW-1:0] top;
  logic [18:0]   ras [RAS_DEPTH];
  logic          acc, cond, push, pop, unf, full, redir;
  logic [18:0]   target;
  // top points at the next free slot; when full that slot holds the oldest entry
  always_comb begin
    acc    = valid_i & is_b_type_ctl_i & !stall_i & (state == RUN);
    cond   = instr_func3_ctl_i < 3'd6;
    push   = acc & (instr_func3_ctl_i == 3'd6);
    pop    = acc & (instr_func3_ctl_i == 3'd7) & (ras_count_o != '0);
    unf    = acc & (instr_func3_ctl_i == 3'd7) & (ras_count_o == '0);
    full   = ras_count_o == CW'(RAS_DEPTH);
    redir  = (acc & cond & branch_taken_i) | push | pop;
    target = pop ? ras[top - 1'b1] : pc_i + imm_i;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_o        <= RESET_PC;
      flush_o     <= 1'b0;
      ras_count_o <= '0;
      ras_ovf_o   <= 1'b0;
      ras_unf_o   <= 1'b0;
      state       <= RUN;
      cnt         <= '0;
      top         <= '0;
    end else if (!stall_i) begin
      pc_o <= redir ? target : pc_o + 19'd1;
      if (push) begin
        top <= top + 1'b1;
        if (full) ras_ovf_o <= 1'b1;
        else ras_count_o <= ras_count_o + 1'b1;
      end
      if (pop) begin
        top         <= top - 1'b1;
        ras_count_o <= ras_count_o - 1'b1;
      end
      if (unf) ras_unf_o <= 1'b1;
      if (redir) begin
        state   <= FLUSH;
        flush_o <= 1'b1;
        cnt     <= 3'(FLUSH_CYCLES - 1);
      end else if (state == FLUSH) begin
        if (cnt == '0) begin
          state   <= RUN;
          flush_o <= 1'b0;
        end else cnt <= cnt - 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) ras[top] <= pc_i + 19'd1;
  end
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: scoreboard bench; a queue-based reference model predicts each cycle's
// outputs, a monitor compares them after every rising edge.
module tb_pc_redirect_ctrl;
  localparam int DEPTH = 8;
  localparam int FLC   = 2;
  localparam logic [18:0] RPC = 19'h0;
  typedef struct {
    logic [18:0] pc;
    logic        fl;
    logic [3:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        valid_i = 0, stall_i = 0, is_b_type_ctl_i = 0, branch_taken_i = 0;
  logic [2:0]  instr_func3_ctl_i = 0;
  logic [18:0] pc_i = 0, imm_i = 0;
  logic [18:0] pc_o;
  logic        flush_o, ras_ovf_o, ras_unf_o;
  logic [3:0]  ras_count_o;
  int          vectors = 0, miscompares = 0;
  exp_t        sb[$];
  exp_t        e;
  logic [18:0] m_pc, ras_q[$];
  int          m_left;
  logic        m_ovf, m_unf;
  logic [18:0] held;

  pc_redirect_ctrl #(.RESET_PC(RPC), .RAS_DEPTH(DEPTH), .FLUSH_CYCLES(FLC)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .stall_i(stall_i),
    .is_b_type_ctl_i(is_b_type_ctl_i), .instr_func3_ctl_i(instr_func3_ctl_i),
    .branch_taken_i(branch_taken_i), .pc_i(pc_i), .imm_i(imm_i), .pc_o(pc_o),
    .flush_o(flush_o), .ras_count_o(ras_count_o), .ras_ovf_o(ras_ovf_o), .ras_unf_o(ras_unf_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_left = 0; m_ovf = 0; m_unf = 0; ras_q = {};
  endtask

  // Called at a falling edge: drive inputs, predict the state after the next rising edge.
  task automatic step(input logic v, st, b, input logic [2:0] f3, input logic tk,
                      input logic [18:0] p, im);
    logic redir;
    logic [18:0] tgt;
    valid_i = v; stall_i = st; is_b_type_ctl_i = b; instr_func3_ctl_i = f3;
    branch_taken_i = tk; pc_i = p; imm_i = im;
    redir = 0; tgt = p + im;
    if (!st) begin
      if (m_left > 0) m_left--;
      else if (v && b) begin
        if (f3 < 6) redir = tk;
        else if (f3 == 6) begin
          if (ras_q.size() == DEPTH) begin void'(ras_q.pop_front()); m_ovf = 1; end
          ras_q.push_back(p + 19'd1);
          redir = 1;
        end else if (ras_q.size() > 0) begin
          tgt = ras_q.pop_back();
          redir = 1;
        end else m_unf = 1;
      end
      if (redir) begin m_pc = tgt; m_left = FLC; end
      else m_pc = m_pc + 19'd1;
    end
    sb.push_back('{pc: m_pc, fl: m_left > 0, cnt: 4'(ras_q.size()), ovf: m_ovf, unf: m_unf});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (pc_o !== e.pc || flush_o !== e.fl || ras_count_o !== e.cnt ||
            ras_ovf_o !== e.ovf || ras_unf_o !== e.unf) begin
          miscompares++;
          $display("FAIL cycle@%0t: got pc=%h fl=%b cnt=%0d ovf=%b unf=%b expected pc=%h fl=%b cnt=%0d ovf=%b unf=%b",
                   $time, pc_o, flush_o, ras_count_o, ras_ovf_o, ras_unf_o,
                   e.pc, e.fl, e.cnt, e.ovf, e.unf);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_pc", 32'(pc_o), 32'(RPC));
    chk("reset_flush", 32'(flush_o), 0);
    chk("reset_cnt", 32'(ras_count_o), 0);
    chk("reset_ovf", 32'(ras_ovf_o), 0);
    chk("reset_unf", 32'(ras_unf_o), 0);
    reset_n = 1;
    idle(3);
    chk("free_run_pc", 32'(pc_o), 3);
    step(1, 0, 1, 0, 1, 19'h00010, 19'h00008);
    chk("beq_target", 32'(pc_o), 32'h18);
    step(1, 0, 1, 0, 1, 19'h00040, 19'h00004);
    idle(2);
    step(1, 0, 1, 0, 0, 19'h00010, 19'h00008);
    idle(2);
    step(1, 0, 1, 6, 0, 19'h00100, 19'h7FF00);
    chk("call_target", 32'(pc_o), 0);
    idle(2);
    step(1, 0, 1, 7, 0, 19'h00200, 19'h00000);
    chk("ret_target", 32'(pc_o), 32'h101);
    idle(2);
    for (int i = 1; i <= 9; i++) begin
      step(1, 0, 1, 6, 1, 19'(i), 19'h00050);
      idle(2);
    end
    chk("ovf_set", 32'(ras_ovf_o), 1);
    chk("ovf_count", 32'(ras_count_o), 8);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, 7, 0, 19'h00300, 19'h0);
      chk("ret_chain", 32'(pc_o), 32'(10 - i));
      idle(2);
    end
    held = pc_o;
    step(1, 0, 1, 7, 0, 19'h00300, 19'h0);
    chk("unf_set", 32'(ras_unf_o), 1);
    chk("unf_noflush", 32'(flush_o), 0);
    chk("unf_pc_inc", 32'(pc_o), 32'(held + 19'd1));
    step(1, 0, 1, 1, 1, 19'h7FFFE, 19'h00003);
    chk("wrap_pc", 32'(pc_o), 1);
    idle(2);
    step(1, 0, 1, 2, 1, 19'h01000, 19'h00020);
    held = pc_o;
    repeat (3) step(1, 1, 1, 0, 1, 19'h02000, 19'h00010);
    chk("stall_hold_pc", 32'(pc_o), 32'(held));
    chk("stall_hold_flush", 32'(flush_o), 1);
    idle(3);
    step(1, 0, 1, 3, 1, 19'h03000, 19'h00100);
    chk("pre_reset_flush", 32'(flush_o), 1);
    #2 reset_n = 0;
    #1;
    chk("async_rst_pc", 32'(pc_o), 32'(RPC));
    chk("async_rst_flush", 32'(flush_o), 0);
    chk("async_rst_cnt", 32'(ras_count_o), 0);
    chk("async_rst_ovf", 32'(ras_ovf_o), 0);
    model_reset();
    valid_i = 0; stall_i = 0; is_b_type_ctl_i = 0;
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 15, $urandom_range(0, 9) < 6,
           3'($urandom_range(0, 7)), 1'($urandom), 19'($urandom), 19'($urandom));
    idle(2);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
